// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks: FSM state encoding,
// parity mode codes and a constant clog2 used to size counters.
package uart_pkg;

  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_RX_START_BIT  = 3'd1,
    s_RX_DATA_BITS  = 3'd2,
    s_RX_PARITY_BIT = 3'd3,
    s_RX_STOP_BIT   = 3'd4,
    s_BREAK_WAIT    = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser with a configurable reset level; used for the RX pin
// and for synchronising reset deassertion.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_D,
  output logic o_Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_D;
      sync_q <= meta_q;
    end
  end

  assign o_Q = sync_q;

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 5..8 data bits, optional parity, 1 or 2 stop bits,
// parity/framing error flags and break detection.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_ext: CLKS_PER_BIT must be 4..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_ext: DATA_BITS must be 5..8");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_rx_ext: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_ext: STOP_BITS must be 1 or 2");
  end

  logic rst_n_s;
  logic rx_s;

  // Reset asserts asynchronously but releases two clocks later, synchronously.
  uart_sync2 #(.RESET_VAL(1'b0)) u_rst_sync (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_D       (1'b1),
    .o_Q       (rst_n_s)
  );

  uart_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .i_Clock   (i_Clock),
    .i_Reset_n (rst_n_s),
    .i_D       (i_RX_Serial),
    .o_Q       (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;

  logic frame_bad;
  logic is_break;
  logic par_xor;
  logic par_mismatch;

  always_ff @(posedge i_Clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= s_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
    end
  end

  // Evaluated at the final stop sample; rx_s is that stop bit itself.
  always_comb begin
    frame_bad = ferr_q | ~rx_s;
    par_xor   = (^data_q) ^ par_q;
    if (PARITY == PARITY_ODD)       par_mismatch = ~par_xor;
    else if (PARITY == PARITY_EVEN) par_mismatch = par_xor;
    else                            par_mismatch = 1'b0;
    is_break  = frame_bad & ~(|data_q) & ((PARITY == PARITY_NONE) | ~par_q);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    perr_d  = 1'b0;
    fe_d    = 1'b0;
    brk_d   = 1'b0;

    case (state_q)
      s_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        par_d   = 1'b0;
        ferr_d  = 1'b0;
        if (!rx_s) state_d = s_RX_START_BIT;
      end

      s_RX_START_BIT: begin
        if (timer_q == HALF_BIT) begin
          timer_d = '0;
          state_d = rx_s ? s_IDLE : s_RX_DATA_BITS;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      s_RX_DATA_BITS: begin
        if (timer_q != BIT_LAST) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d        = '0;
          data_d[idx_q]  = rx_s;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? s_RX_PARITY_BIT : s_RX_STOP_BIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      s_RX_PARITY_BIT: begin
        if (timer_q != BIT_LAST) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = '0;
          par_d   = rx_s;
          state_d = s_RX_STOP_BIT;
        end
      end

      s_RX_STOP_BIT: begin
        if (timer_q != BIT_LAST) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (idx_q == STOP_LAST) begin
            dv_d    = 1'b1;
            fe_d    = frame_bad;
            brk_d   = is_break;
            perr_d  = par_mismatch;
            byte_d  = is_break ? '0 : data_q;
            state_d = is_break ? s_BREAK_WAIT : s_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      s_BREAK_WAIT: begin
        if (rx_s) state_d = s_IDLE;
      end

      default: state_d = s_IDLE;
    endcase
  end

  // o_RX_DV is a valid-only strobe (no ready): byte and flags are meaningful
  // only in the cycle it is high, and the consumer must take them then.
  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = fe_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: four instances cover 8N1, even parity,
// two stop bits and 7 data bits; received frames are logged and checked.
module tb_uart_rx_ext;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] rx_line;

  logic [3:0] dv, pe, fe, brk, busy;
  logic [7:0] b0, b1, b2;
  logic [6:0] b3;

  int total;
  int bad;

  // {break, frame_err, parity_err, byte}
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] q2[$];
  logic [10:0] q3[$];

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx_line[0]),
    .o_RX_DV(dv[0]), .o_RX_Byte(b0), .o_Parity_Err(pe[0]),
    .o_Frame_Err(fe[0]), .o_Break(brk[0]), .o_Busy(busy[0])
  );

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_par (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx_line[1]),
    .o_RX_DV(dv[1]), .o_RX_Byte(b1), .o_Parity_Err(pe[1]),
    .o_Frame_Err(fe[1]), .o_Break(brk[1]), .o_Busy(busy[1])
  );

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx_line[2]),
    .o_RX_DV(dv[2]), .o_RX_Byte(b2), .o_Parity_Err(pe[2]),
    .o_Frame_Err(fe[2]), .o_Break(brk[2]), .o_Busy(busy[2])
  );

  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_Serial(rx_line[3]),
    .o_RX_DV(dv[3]), .o_RX_Byte(b3), .o_Parity_Err(pe[3]),
    .o_Frame_Err(fe[3]), .o_Break(brk[3]), .o_Busy(busy[3])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame log: one entry per strobe cycle, so a stretched strobe shows up as extras
  always @(negedge clk) begin
    if (dv[0]) q0.push_back({brk[0], fe[0], pe[0], b0});
    if (dv[1]) q1.push_back({brk[1], fe[1], pe[1], b1});
    if (dv[2]) q2.push_back({brk[2], fe[2], pe[2], b2});
    if (dv[3]) q3.push_back({brk[3], fe[3], pe[3], 1'b0, b3});
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic expect_frame(input int k, input string tag, input logic [10:0] exp);
    logic [10:0] w;
    int n;
    n = qsize(k);
    check_val({tag, " present"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
    if (n > 0) begin
      case (k)
        0: w = q0.pop_front();
        1: w = q1.pop_front();
        2: w = q2.pop_front();
        default: w = q3.pop_front();
      endcase
      check_val(tag, {21'd0, w}, {21'd0, exp});
    end
  endtask

  // driver tasks
  task automatic drive_bit(input int k, input logic v);
    rx_line[k] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] data, input int nbits,
                            input bit has_par, input logic pbit,
                            input int nstop, input logic stop2);
    drive_bit(k, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(k, data[i]);
    if (has_par) drive_bit(k, pbit);
    drive_bit(k, 1'b1);
    if (nstop == 2) drive_bit(k, stop2);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rx_line = 4'hF;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check_val("rst dv", {31'd0, dv[0]}, 32'd0);
    check_val("rst byte", {24'd0, b0}, 32'd0);
    check_val("rst flags", {29'd0, pe[0], fe[0], brk[0]}, 32'd0);
    check_val("rst busy", {28'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(1);

    // 8N1 0xA5
    send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(0, "8n1 a5", 11'h0A5);
    check_val("8n1 busy after", {31'd0, busy[0]}, 32'd0);

    // even parity 0x37 (five ones): parity bit 1 good, 0 bad
    send_frame(1, 8'h37, 8, 1'b1, 1'b1, 1, 1'b1);
    idle_bits(1);
    expect_frame(1, "par ok", 11'h037);
    send_frame(1, 8'h37, 8, 1'b1, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(1, "par err", 11'h137);

    // two stop bits: second stop low, then two frames with no gap
    send_frame(2, 8'h55, 8, 1'b0, 1'b0, 2, 1'b0);
    rx_line[2] = 1'b1;
    idle_bits(2);
    expect_frame(2, "stop2 ferr", 11'h255);
    send_frame(2, 8'h3C, 8, 1'b0, 1'b0, 2, 1'b1);
    send_frame(2, 8'h3C, 8, 1'b0, 1'b0, 2, 1'b1);
    idle_bits(1);
    expect_frame(2, "b2b first", 11'h03C);
    expect_frame(2, "b2b second", 11'h03C);
    check_val("stop2 no extra", qsize(2), 32'd0);

    // 3-clock glitch
    rx_line[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx_line[0] = 1'b1;
    idle_bits(2);
    check_val("glitch no dv", qsize(0), 32'd0);
    check_val("glitch idle", {31'd0, busy[0]}, 32'd0);
    send_frame(0, 8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(0, "after glitch", 11'h081);

    // break: line low for 20 bit times
    rx_line[0] = 1'b0;
    idle_bits(20);
    check_val("break one dv", qsize(0), 32'd1);
    check_val("break wait busy", {31'd0, busy[0]}, 32'd1);
    rx_line[0] = 1'b1;
    idle_bits(2);
    check_val("break released", {31'd0, busy[0]}, 32'd0);
    expect_frame(0, "break", 11'h600);
    send_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(0, "after break", 11'h0C3);

    // reset mid data bit 4 of 0xFF
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    rx_line[0] = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst byte", {24'd0, b0}, 32'd0);
    check_val("midrst busy", {31'd0, busy[0]}, 32'd0);
    check_val("midrst dv", {31'd0, dv[0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(4);
    check_val("midrst no dv", qsize(0), 32'd0);
    send_frame(0, 8'h12, 8, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(0, "after rst", 11'h012);

    // 7 data bits
    send_frame(3, 8'h5A, 7, 1'b0, 1'b0, 1, 1'b1);
    idle_bits(1);
    expect_frame(3, "7bit 5a", 11'h05A);

    check_val("end q0 empty", qsize(0), 32'd0);
    check_val("end q1 empty", qsize(1), 32'd0);
    check_val("end q3 empty", qsize(3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
